// File: rtl/serial_arbiter.sv
// rtl/serial_arbiter.sv - round-robin, frame-locked arbiter sharing one serial byte transmitter
// Grant is held from the first byte of a frame until its last byte transfers.
module serial_arbiter #(
   parameter int N = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req_stb,
   input  logic [8*N-1:0] req_dat,
   input  logic [N-1:0]   req_lst,
   output logic [N-1:0]   req_rdy,
   output logic           stb,
   output logic [7:0]     dat,
   input  logic           rdy,
   output logic [N-1:0]   grt
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state;
   logic [PW-1:0] ptr;
   logic [PW-1:0] gidx;
   logic [PW-1:0] sel;
   logic          found;
   logic          busy;
   logic          last_xfer;

   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input int b);
      int s;
      s = int'(a) + b;
      if (s >= N) s = s - N;
      return s[PW-1:0];
   endfunction

   // First requesting index at or after ptr, wrapping modulo N.
   always_comb begin
      sel   = ptr;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!found && req_stb[wrap_add(ptr, k)]) begin
            sel   = wrap_add(ptr, k);
            found = 1'b1;
         end
      end
   end

   assign busy      = (state == BUSY);
   assign stb       = busy & req_stb[gidx];
   assign dat       = busy ? req_dat[8*gidx +: 8] : 8'h00;
   assign req_rdy   = grt & {N{rdy}};
   assign last_xfer = req_stb[gidx] & rdy & req_lst[gidx];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= '0;
         gidx  <= '0;
         grt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  state <= BUSY;
                  gidx  <= sel;
                  grt   <= {{(N-1){1'b0}}, 1'b1} << sel;
               end
            end
            BUSY: begin
               if (last_xfer) begin
                  state <= IDLE;
                  ptr   <= wrap_add(gidx, 1);
                  grt   <= '0;
               end
            end
         endcase
      end
   end

endmodule
